// File: rtl/spi_rdid_slave.sv
// spi_rdid_slave: SPI mode-0 flash-side responder that answers RDID (0x9F) with a 3-byte JEDEC ID.
//   clk, reset (async, active-high); sclk, cs_n, mosi are asynchronous SPI pins, oversampled in clk.
//   miso/miso_oe drive the pad; cmd_strobe/cmd_byte report opcodes; resp_done marks the end of the response;
//   busy tracks synchronized chip select. Define SPI_RDID_SLAVE_RDSR_EN to also answer RDSR (0x05).
module spi_rdid_slave #(
  parameter logic [7:0] MFG_ID     = 8'h20,
  parameter logic [7:0] MEM_TYPE   = 8'h20,
  parameter logic [7:0] MEM_CAP    = 8'h15,
  parameter logic [7:0] STATUS_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic       resp_done,
  output logic       busy
);
`ifdef SPI_RDID_SLAVE_RDSR_EN
  localparam bit RDSR_EN = 1'b1;
`else
  localparam bit RDSR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;
  state_t state, state_nx;
  logic sclk_m, sclk_s, sclk_d, cs_m, cs_s, mosi_m, mosi_s;
  logic rise, fall, is_rdid, is_rdsr, rdsr, rdsr_nx;
  logic [4:0] cnt, cnt_nx;
  logic [6:0] csr, csr_nx;
  logic [7:0] op, byte_nx;
  logic [23:0] sh, sh_nx;
  logic miso_nx, oe_nx, strobe_nx, done_nx;
  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;
  assign op = {csr, mosi_s};
  assign is_rdid = op == 8'h9F;
  assign is_rdsr = RDSR_EN && op == 8'h05;
  assign busy = ~cs_s;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {sclk_m, sclk_s, sclk_d, mosi_m, mosi_s} <= '0;
      {cs_m, cs_s} <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      csr <= '0;
      sh <= '0;
      rdsr <= 1'b0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_byte <= '0;
      resp_done <= 1'b0;
    end else begin
      {sclk_m, sclk_s, sclk_d} <= {sclk, sclk_m, sclk_s};
      {cs_m, cs_s} <= {cs_n, cs_m};
      {mosi_m, mosi_s} <= {mosi, mosi_m};
      state <= state_nx;
      cnt <= cnt_nx;
      csr <= csr_nx;
      sh <= sh_nx;
      rdsr <= rdsr_nx;
      miso <= miso_nx;
      miso_oe <= oe_nx;
      cmd_strobe <= strobe_nx;
      cmd_byte <= byte_nx;
      resp_done <= done_nx;
    end
  // Chip-select release is checked first so it overrides any sclk edge seen in the same clk.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    csr_nx = csr;
    sh_nx = sh;
    rdsr_nx = rdsr;
    miso_nx = miso;
    oe_nx = miso_oe;
    strobe_nx = 1'b0;
    byte_nx = cmd_byte;
    done_nx = 1'b0;
    if (cs_s) begin
      state_nx = IDLE;
      cnt_nx = '0;
      csr_nx = '0;
      rdsr_nx = 1'b0;
      miso_nx = 1'b0;
      oe_nx = 1'b0;
    end else
      case (state)
        IDLE: begin
          state_nx = CMD;
          cnt_nx = '0;
        end
        CMD: if (rise) begin
          csr_nx = op[6:0];
          cnt_nx = cnt + 5'd1;
          if (cnt == 5'd7) begin
            byte_nx = op;
            strobe_nx = 1'b1;
            cnt_nx = '0;
            state_nx = (is_rdid || is_rdsr) ? RESP : IGNORE;
            oe_nx = is_rdid || is_rdsr;
            rdsr_nx = is_rdsr;
            sh_nx = is_rdsr ? {STATUS_VAL, 16'h0} : {MFG_ID, MEM_TYPE, MEM_CAP};
          end
        end
        RESP: begin
          // RDSR rotates the status byte so it repeats; RDID drains to zeros after 24 bits.
          if (fall) begin
            miso_nx = sh[23];
            sh_nx = rdsr ? {sh[22:16], sh[23], 16'h0} : {sh[22:0], 1'b0};
          end
          if (rise && cnt != 5'd24) begin
            cnt_nx = cnt + 5'd1;
            done_nx = cnt == (rdsr ? 5'd7 : 5'd23);
          end
        end
        default: begin
          miso_nx = 1'b0;
          oe_nx = 1'b0;
        end
      endcase
  end
endmodule

// File: tb/tb_spi_rdid_slave.sv
// tb_spi_rdid_slave: directed table-driven bench for spi_rdid_slave acting as an SPI mode-0 master.
module tb_spi_rdid_slave;
  logic clk = 0, reset = 1, sclk = 0, cs_n = 1, mosi = 0;
  logic miso, miso_oe, cmd_strobe, resp_done, busy;
  logic [7:0] cmd_byte;
  int tests = 0, fails = 0, n_str = 0, n_done = 0, n_oe = 0;
  spi_rdid_slave #(.STATUS_VAL(8'hA5)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte), .resp_done(resp_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (cmd_strobe) n_str++;
    if (resp_done) n_done++;
    if (miso_oe) n_oe++;
  end
  typedef struct {
    logic [7:0]  op;
    int          n;
    logic [31:0] exp;
    bit          oe;
    int          done;
  } vec_t;
  vec_t v[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7-i];
      clks(5);
      sclk = 1;
      rx = {rx[6:0], miso};
      clks(5);
      sclk = 0;
    end
  endtask
  task automatic frame(input logic [7:0] op, input int n, input logic [31:0] exp, input bit oe, input int done);
    int s0, d0, o0;
    logic [7:0] rx;
    s0 = n_str; d0 = n_done; o0 = n_oe;
    clks(1);
    cs_n = 0;
    clks(5);
    chk("busy_in_frame", busy, 1);
    spi_bits(op, 8, rx);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx);
      chk($sformatf("op%0h_byte%0d", op, i), rx, exp[31-8*i -: 8]);
    end
    clks(5);
    cs_n = 1;
    clks(5);
    chk($sformatf("op%0h_strobes", op), n_str - s0, 1);
    chk($sformatf("op%0h_cmd_byte", op), cmd_byte, op);
    chk($sformatf("op%0h_resp_done", op), n_done - d0, done);
    chk($sformatf("op%0h_oe_seen", op), (n_oe - o0) != 0, oe);
    chk($sformatf("op%0h_oe_after", op), miso_oe, 0);
    chk($sformatf("op%0h_busy_after", op), busy, 0);
  endtask
  initial begin
    logic [7:0] rx;
    int s0, d0;
    v[0] = '{8'h9F, 4, 32'h20201500, 1'b1, 1};
    v[1] = '{8'h03, 2, 32'h00000000, 1'b0, 0};
`ifdef SPI_RDID_SLAVE_RDSR_EN
    v[2] = '{8'h05, 2, 32'hA5A50000, 1'b1, 1};
`else
    v[2] = '{8'h05, 2, 32'h00000000, 1'b0, 0};
`endif
    v[3] = '{8'h9F, 3, 32'h20201500, 1'b1, 1};
    v[4] = '{8'hC7, 1, 32'h00000000, 1'b0, 0};
    #100;
    @(negedge clk);
    reset = 0;
    clks(3);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_byte", cmd_byte, 0);
    chk("rst_pulses", n_str + n_done, 0);
    for (int i = 0; i < 5; i++) frame(v[i].op, v[i].n, v[i].exp, v[i].oe, v[i].done);
    // opcode abandoned after 5 bits
    s0 = n_str;
    cs_n = 0;
    clks(5);
    spi_bits(8'h9F, 5, rx);
    cs_n = 1;
    clks(5);
    chk("partial_op_strobe", n_str - s0, 0);
    chk("partial_op_cmd_byte", cmd_byte, 8'hC7);
    frame(8'h9F, 3, 32'h20201500, 1'b1, 1);
    // response abandoned after 10 bits
    s0 = n_str; d0 = n_done;
    cs_n = 0;
    clks(5);
    spi_bits(8'h9F, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("partial_resp_byte0", rx, 8'h20);
    spi_bits(8'h00, 2, rx);
    cs_n = 1;
    clks(3);
    chk("partial_resp_oe_3clk", miso_oe, 0);
    clks(5);
    chk("partial_resp_done", n_done - d0, 0);
    chk("partial_resp_strobe", n_str - s0, 1);
    frame(8'h9F, 3, 32'h20201500, 1'b1, 1);
    // reset mid-response, released with cs_n still low
    cs_n = 0;
    clks(5);
    spi_bits(8'h9F, 8, rx);
    spi_bits(8'h00, 4, rx);
    reset = 1;
    #1;
    chk("midrst_oe", miso_oe, 0);
    chk("midrst_cmd_byte", cmd_byte, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_miso", miso, 0);
    clks(3);
    reset = 0;
    clks(5);
    d0 = n_done;
    spi_bits(8'h9F, 8, rx);
    chk("midrst_cmd_byte_new", cmd_byte, 8'h9F);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'h00, 8, rx);
      chk($sformatf("midrst_byte%0d", i), rx, i == 2 ? 8'h15 : 8'h20);
    end
    clks(5);
    chk("midrst_done", n_done - d0, 1);
    cs_n = 1;
    clks(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
